id_operand_fetch: RTL and testbench
===================================

Name: id_operand_fetch

Overview:
- Decode / operand-fetch stage directly upstream of the 32x32 register file.
- Accepts 32-bit MIPS-style instructions over a valid/ready handshake and decodes register fields and immediate.
- Drives the register file read ports and tracks in-flight destinations with a busy scoreboard, stalling on read-after-write hazards.
- Presents operands plus decoded control to the execute stage over a second valid/ready handshake.

Parameters:
- DATA_W, 32: instruction and operand width; the register file fixes this at 32.
- ADDR_W, 5: register index width; 2**ADDR_W registers.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous drop of the held instruction.
- in_valid  in  1  instruction valid.
- in_instr  in  DATA_W  instruction word.
- in_ready  out  1  stage can accept an instruction.
- read_reg1  out  ADDR_W  register file read index 1 (rs).
- read_en1  out  1  register file read enable 1.
- read_reg2  out  ADDR_W  register file read index 2 (rt).
- read_en2  out  1  register file read enable 2.
- read_data1_i  in  DATA_W  register file read data 1.
- read_data2_i  in  DATA_W  register file read data 2.
- wb_en  in  1  writeback this cycle; the register file is written at this cycle's negedge.
- wb_reg  in  ADDR_W  writeback destination index.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute stage accepts.
- out_op_a  out  DATA_W  rs value.
- out_op_b  out  DATA_W  rt value.
- out_imm  out  DATA_W  extended immediate.
- out_opcode  out  6  instr[31:26].
- out_funct  out  6  instr[5:0].
- out_rd  out  ADDR_W  destination index.
- out_wen  out  1  instruction writes a register.

Behaviour:
- State machine: IDLE, READ, OUT. Reset: IDLE, instruction register 0, scoreboard all 0. Every output is 0 during reset, including in_ready, out_valid, read_en1/2 and out_op_a/b.
- IDLE: in_ready=1. in_valid latches in_instr and moves to READ.
- Decode of the latched instruction:
  - opcode 0x00: sources rs and rt; dest rd.
  - 0x08/09/0A/0B/0C/0D/0E/0F/0x23: source rs only; dest rt.
  - 0x2B/04/05: sources rs and rt; no dest.
  - Any other opcode: no sources, no dest (NOP).
  - out_wen = has dest and dest != 0.
- Immediate:
  - Zero-extended for 0x0C/0D/0E.
  - {imm16,16'b0} for 0x0F.
  - Sign-extended otherwise.
  - 0 for opcode 0x00.
- Hazard: a source is blocked if scoreboard[src]=1, src!=0, and not (wb_en && wb_reg==src). A same-cycle writeback is visible because the register file writes at negedge and reads at posedge.
- READ:
  - read_reg1=rs and read_reg2=rt at all times in this state.
  - If no source is blocked: read_en1/read_en2 are asserted for the used sources only, and the next state is OUT. The register file captures the data on that edge.
  - Otherwise enables stay 0 and the state stays READ.
- OUT:
  - out_valid=1. out_op_a/out_op_b are driven combinationally from read_data1_i/read_data2_i, which stay stable because the enables are 0. An unused source presents 0.
  - out_valid && out_ready returns to IDLE.
  - Zero-bubble chaining is not supported: in_ready=0 outside IDLE. Throughput is at most one instruction per 3 cycles.
- Scoreboard:
  - Set bit out_rd on the out handshake when out_wen=1.
  - Clear bit wb_reg when wb_en=1.
  - Set and clear of the same index in one cycle: set wins.
  - Bit 0 is never set.
- flush: forces IDLE next edge and discards the instruction with no scoreboard set. It overrides a simultaneous out handshake. Scoreboard clears continue; existing busy bits are untouched.
- rst_n low mid-operation: immediate return to reset state, and in-flight scoreboard bits are lost.

Test Plan:
- Reset release, then instruction 0x012A4020 (add $8,$9,$10) with $9=5, $10=7 → read_reg1=9, read_reg2=10; out_valid 2 cycles after accept, op_a=5, op_b=7, out_rd=8, out_wen=1; scoreboard[8]=1 after handshake.
- Follow with addi $11,$8,-1 (0x210BFFFF) while $8 is pending → stalls in READ with read_en1=0. wb_en=1, wb_reg=8, write 12 → proceeds in that same cycle; op_a=12, imm=0xFFFFFFFF.
- ori $3,$0,0x8000 → imm=0x00008000, read_en2=0, op_b=0. lui → imm=0x80000000.
- out_ready held 0 for 4 cycles in OUT → out_valid and operands stable, in_ready=0; handshake on cycle 5.
- Same-cycle out handshake setting rd=8 and wb_en clearing 8 → scoreboard[8]=1 afterward.
- flush in READ; rst_n pulsed in OUT → returns to IDLE; no scoreboard set from the flushed instruction; all outputs 0 during reset.

Source files
------------

// File: rtl/id_operand_fetch.sv
// id_operand_fetch: decode / operand-fetch stage in front of the 32x32 register file.
// Holds one instruction, waits out read-after-write hazards against a busy
// scoreboard, reads the register file, then presents operands to execute.
//
// state | meaning
// IDLE  | empty; accepts an instruction when in_valid
// READ  | instruction held; waits for sources to clear, then reads the register file
// OUT   | operands and decoded control presented; waits for out_ready
module id_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  output logic [ADDR_W-1:0] read_reg1,
  output logic              read_en1,
  output logic [ADDR_W-1:0] read_reg2,
  output logic              read_en2,
  input  logic [DATA_W-1:0] read_data1_i,
  input  logic [DATA_W-1:0] read_data2_i,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rs, rt, rd, dest;
  logic [15:0]       imm16;
  logic              use_rs, use_rt, has_dest, wen;
  logic [DATA_W-1:0] imm;
  logic              blocked1, blocked2, stall, out_fire;

  assign opcode = instr_q[DATA_W-1 -: 6];
  assign funct  = instr_q[5:0];
  assign rs     = instr_q[21 +: ADDR_W];
  assign rt     = instr_q[16 +: ADDR_W];
  assign rd     = instr_q[11 +: ADDR_W];
  assign imm16  = instr_q[15:0];

  // Decode source usage and destination of the held instruction.
  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    has_dest = 1'b0;
    dest     = '0;
    case (opcode)
      6'h00: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        has_dest = 1'b1;
        dest     = rd;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
        use_rs   = 1'b1;
        has_dest = 1'b1;
        dest     = rt;
      end
      6'h2B, 6'h04, 6'h05: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: ;
    endcase
    wen = has_dest && (dest != '0);
  end

  // Immediate extension: logical ops zero-extend, lui shifts up, R-type has none.
  always_comb begin
    imm = {{(DATA_W-16){imm16[15]}}, imm16};
    case (opcode)
      6'h00:               imm = '0;
      6'h0C, 6'h0D, 6'h0E: imm = {{(DATA_W-16){1'b0}}, imm16};
      6'h0F:               imm = {imm16, {(DATA_W-16){1'b0}}};
      default: ;
    endcase
  end

  // A writeback in this cycle lands at negedge, before the posedge read, so it unblocks now.
  always_comb begin
    blocked1 = use_rs && (rs != '0) && busy_q[rs] && !(wb_en && (wb_reg == rs));
    blocked2 = use_rt && (rt != '0) && busy_q[rt] && !(wb_en && (wb_reg == rt));
    stall    = blocked1 || blocked2;
    out_fire = out_valid_q && out_ready;
  end

  // Next-state, instruction capture and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        if (!flush && in_valid && in_ready_q) begin
          state_d = READ;
          instr_d = in_instr;
        end
      end
      READ: begin
        if (flush)       state_d = IDLE;
        else if (!stall) state_d = OUT;
      end
      OUT: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  // Scoreboard: set on issue to execute (wins over a same-index clear), never for r0.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_reg] = 1'b0;
    if (out_fire && wen && !flush) busy_d[dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // FSM state, held instruction and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Busy bits for in-flight destinations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign read_reg1  = rs;
  assign read_reg2  = rt;
  assign read_en1   = (state_q == READ) && !stall && use_rs;
  assign read_en2   = (state_q == READ) && !stall && use_rt;
  // Register file data is held stable in OUT since the read enables are low there.
  assign out_op_a   = (out_valid_q && use_rs) ? read_data1_i : '0;
  assign out_op_b   = (out_valid_q && use_rt) ? read_data2_i : '0;
  assign out_imm    = imm;
  assign out_opcode = opcode;
  assign out_funct  = funct;
  assign out_rd     = has_dest ? dest : '0;
  assign out_wen    = wen;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch with a small register file model and an
// expected-result queue popped on every execute handshake.
module tb_id_operand_fetch;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic [4:0]  read_reg1, read_reg2;
  logic        read_en1, read_en2;
  logic [31:0] read_data1_i = 32'hDEAD_BEEF;
  logic [31:0] read_data2_i = 32'hCAFE_F00D;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_op_a, out_op_b, out_imm;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rd;
  logic        out_wen;

  logic [31:0] regs [32];
  exp_t        sbq [$];
  int          errors = 0;
  int          checks = 0;
  exp_t        dummy = '0;

  always #5 clk = ~clk;

  id_operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .read_reg1(read_reg1), .read_en1(read_en1),
    .read_reg2(read_reg2), .read_en2(read_en2),
    .read_data1_i(read_data1_i), .read_data2_i(read_data2_i),
    .wb_en(wb_en), .wb_reg(wb_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_funct(out_funct),
    .out_rd(out_rd), .out_wen(out_wen)
  );

  // Register file model: write at negedge, registered read at posedge when enabled.
  always @(negedge clk) if (wb_en && wb_reg != 5'd0) regs[wb_reg] = wb_data;
  always @(posedge clk) begin
    if (read_en1) read_data1_i <= regs[read_reg1];
    if (read_en2) read_data2_i <= regs[read_reg2];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                              input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] rd,
                              input logic wen);
    exp_t e;
    e.a = a; e.b = b; e.imm = imm; e.opc = opc; e.fn = fn; e.rd = rd; e.wen = wen;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] instr, input bit push, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    #1;
    while (!in_ready && n < 10) begin step(); #1; n++; end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_timeout: in_ready got %0b expected 1", in_ready); end
    if (push) sbq.push_back(e);
    step();
    in_valid = 1'b0;
    #2;
  endtask

  // Execute-side handshake: pops the oldest expectation and compares the presented bundle.
  task automatic handshake();
    exp_t e;
    out_ready = 1'b1;
    #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++; $display("FAIL sb_empty: handshake with queue size %0d expected >0", sbq.size());
    end else begin
      e = sbq.pop_front();
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %0b expected 1", out_valid); end
      checks++; if (out_op_a !== e.a) begin errors++; $display("FAIL sb_op_a: got %0h expected %0h", out_op_a, e.a); end
      checks++; if (out_op_b !== e.b) begin errors++; $display("FAIL sb_op_b: got %0h expected %0h", out_op_b, e.b); end
      checks++; if (out_imm !== e.imm) begin errors++; $display("FAIL sb_imm: got %0h expected %0h", out_imm, e.imm); end
      checks++; if (out_opcode !== e.opc) begin errors++; $display("FAIL sb_opcode: got %0h expected %0h", out_opcode, e.opc); end
      checks++; if (out_funct !== e.fn) begin errors++; $display("FAIL sb_funct: got %0h expected %0h", out_funct, e.fn); end
      checks++; if (out_rd !== e.rd) begin errors++; $display("FAIL sb_rd: got %0d expected %0d", out_rd, e.rd); end
      checks++; if (out_wen !== e.wen) begin errors++; $display("FAIL sb_wen: got %0b expected %0b", out_wen, e.wen); end
    end
    step();
    out_ready = 1'b0;
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!out_valid && n < 10) begin step(); #2; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_timeout: out_valid got %0b expected 1", out_valid); end
    else handshake();
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_instr = 32'h012A4020; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if ({read_en1, read_en2} !== 2'b00) begin errors++; $display("FAIL reset_read_en: got %0b expected 0", {read_en1, read_en2}); end
    checks++; if (out_op_a !== 32'h0) begin errors++; $display("FAIL reset_op_a: got %0h expected 0", out_op_a); end
    checks++; if (out_op_b !== 32'h0) begin errors++; $display("FAIL reset_op_b: got %0h expected 0", out_op_b); end
    checks++; if ({read_reg1, read_reg2, out_rd, out_wen} !== 16'h0) begin errors++; $display("FAIL reset_regs: got %0h expected 0", {read_reg1, read_reg2, out_rd, out_wen}); end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_instr = 32'h012A4020;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %0b expected 1", in_ready); end
    sbq.push_back(mk(32'd5, 32'd7, 32'h0, 6'h00, 6'h20, 5'd8, 1'b1));
    step(); in_valid = 1'b0; #2;
    checks++; if (read_reg1 !== 5'd9) begin errors++; $display("FAIL add_read_reg1: got %0d expected 9", read_reg1); end
    checks++; if (read_reg2 !== 5'd10) begin errors++; $display("FAIL add_read_reg2: got %0d expected 10", read_reg2); end
    checks++; if ({read_en1, read_en2} !== 2'b11) begin errors++; $display("FAIL add_read_en: got %0b expected 11", {read_en1, read_en2}); end
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL add_read_state: got %0b expected 00", {out_valid, in_ready}); end
    step(); #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %0b expected 1", out_valid); end
    handshake();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL add_back_idle: got %0b expected 01", {out_valid, in_ready}); end
  endtask

  task automatic test_hazard();
    accept(32'h210BFFFF, 1'b1, mk(32'd12, 32'h0, 32'hFFFF_FFFF, 6'h08, 6'h3F, 5'd11, 1'b1));
    checks++; if (read_reg1 !== 5'd8) begin errors++; $display("FAIL hz_read_reg1: got %0d expected 8", read_reg1); end
    checks++; if ({read_en1, read_en2} !== 2'b00) begin errors++; $display("FAIL hz_stall_en: got %0b expected 00", {read_en1, read_en2}); end
    step(); #2;
    checks++; if ({read_en1, out_valid} !== 2'b00) begin errors++; $display("FAIL hz_still_stalled: got %0b expected 00", {read_en1, out_valid}); end
    wb_en = 1'b1; wb_reg = 5'd8; wb_data = 32'd12;
    #1;
    checks++; if (read_en1 !== 1'b1) begin errors++; $display("FAIL hz_wb_release: got %0b expected 1", read_en1); end
    step(); wb_en = 1'b0; #2;
    checks++; if (out_op_a !== 32'd12) begin errors++; $display("FAIL hz_op_a: got %0h expected c", out_op_a); end
    drain();
  endtask

  task automatic test_imm();
    accept(32'h34038000, 1'b1, mk(32'h0, 32'h0, 32'h0000_8000, 6'h0D, 6'h00, 5'd3, 1'b1));
    checks++; if ({read_en1, read_en2} !== 2'b10) begin errors++; $display("FAIL ori_read_en: got %0b expected 10", {read_en1, read_en2}); end
    drain();
    accept(32'h3C048000, 1'b1, mk(32'h0, 32'h0, 32'h8000_0000, 6'h0F, 6'h00, 5'd4, 1'b1));
    drain();
    accept(32'h3122FFFF, 1'b1, mk(32'd5, 32'h0, 32'h0000_FFFF, 6'h0C, 6'h3F, 5'd2, 1'b1));
    drain();
    accept(32'hAD2AFFFC, 1'b1, mk(32'd5, 32'd7, 32'hFFFF_FFFC, 6'h2B, 6'h3C, 5'd0, 1'b0));
    drain();
    accept(32'h08000010, 1'b1, mk(32'h0, 32'h0, 32'h0000_0010, 6'h02, 6'h10, 5'd0, 1'b0));
    checks++; if ({read_en1, read_en2} !== 2'b00) begin errors++; $display("FAIL nop_read_en: got %0b expected 00", {read_en1, read_en2}); end
    drain();
  endtask

  task automatic test_backpressure();
    accept(32'h012A2820, 1'b1, mk(32'd5, 32'd7, 32'h0, 6'h00, 6'h20, 5'd5, 1'b1));
    step(); #2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, in_ready, out_op_a, out_op_b} !== {1'b1, 1'b0, 32'd5, 32'd7}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%0b r=%0b a=%0h b=%0h expected v=1 r=0 a=5 b=7",
                           i, out_valid, in_ready, out_op_a, out_op_b);
      end
      step(); #2;
    end
    handshake();
  endtask

  task automatic test_same_cycle();
    accept(32'h012A4020, 1'b1, mk(32'd5, 32'd7, 32'h0, 6'h00, 6'h20, 5'd8, 1'b1));
    step(); #2;
    wb_en = 1'b1; wb_reg = 5'd8; wb_data = 32'd99;
    handshake();
    wb_en = 1'b0;
    accept(32'h210BFFFF, 1'b1, mk(32'd12, 32'h0, 32'hFFFF_FFFF, 6'h08, 6'h3F, 5'd11, 1'b1));
    checks++; if (read_en1 !== 1'b0) begin errors++; $display("FAIL same_cycle_set_wins: read_en1 got %0b expected 0", read_en1); end
    step(); #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_stall: out_valid got %0b expected 0", out_valid); end
    wb_en = 1'b1; wb_reg = 5'd8; wb_data = 32'd12;
    step(); wb_en = 1'b0; #2;
    drain();
  endtask

  task automatic test_flush();
    accept(32'h012A3020, 1'b0, dummy);
    checks++; if (read_en1 !== 1'b1) begin errors++; $display("FAIL flush_read_en: got %0b expected 1", read_en1); end
    flush = 1'b1; step(); flush = 1'b0; #2;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_read_idle: got %0b expected 01", {out_valid, in_ready}); end
    accept(32'h012A3020, 1'b0, dummy);
    step(); #2;
    out_ready = 1'b1; flush = 1'b1; step(); out_ready = 1'b0; flush = 1'b0; #2;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_out_idle: got %0b expected 01", {out_valid, in_ready}); end
    accept(32'h20C70001, 1'b1, mk(regs[6], 32'h0, 32'h1, 6'h08, 6'h01, 5'd7, 1'b1));
    checks++; if (read_en1 !== 1'b1) begin errors++; $display("FAIL flush_no_busy6: read_en1 got %0b expected 1", read_en1); end
    drain();
  endtask

  task automatic test_reset_mid();
    accept(32'h012A6020, 1'b1, mk(32'd5, 32'd7, 32'h0, 6'h00, 6'h20, 5'd12, 1'b1));
    drain();
    accept(32'h012A6820, 1'b0, dummy);
    step(); #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_in_out: got %0b expected 1", out_valid); end
    rst_n = 1'b0; #1;
    checks++; if ({in_ready, out_valid, read_en1, read_en2, out_wen} !== 5'b0) begin errors++; $display("FAIL rst_mid_ctrl: got %0b expected 0", {in_ready, out_valid, read_en1, read_en2, out_wen}); end
    checks++; if ({out_op_a, out_op_b} !== 64'h0) begin errors++; $display("FAIL rst_mid_ops: got %0h expected 0", {out_op_a, out_op_b}); end
    step(); #2;
    rst_n = 1'b1;
    step(); #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %0b expected 1", in_ready); end
    accept(32'h21870001, 1'b1, mk(regs[12], 32'h0, 32'h1, 6'h08, 6'h01, 5'd7, 1'b1));
    checks++; if (read_en1 !== 1'b1) begin errors++; $display("FAIL rst_busy12_lost: read_en1 got %0b expected 1", read_en1); end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i * 3);
    regs[0] = 32'h0;
    regs[9] = 32'd5;
    regs[10] = 32'd7;
    test_reset();
    test_add();
    test_hazard();
    test_imm();
    test_backpressure();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
